// File: rtl/mips_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_run_ctrl                                                   |
// | Purpose  : Execution controller for the MIPS core. Turns the run/step      |
// |            switch and step button into a per-cycle core enable, handles    |
// |            PC breakpoints and halt instructions, and counts retired        |
// |            instructions for debug display.                                 |
// | Options  : `define MIPS_RUN_CTRL_BREAKPOINT_EN enables the PC breakpoint.  |
// |            Without it bp_en/bp_addr are ignored and BREAK never occurs.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips_run_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 run_mode,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 halt_req,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  output logic                 cpu_en,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    PAUSED = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    BREAK  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_halted;
  logic [CNT_WIDTH-1:0]   r_instr_count;
  logic [SYNC_STAGES-1:0] r_step_sync;
  logic [SYNC_STAGES-1:0] r_run_sync;
  logic                   r_step_prev;

  logic w_step_s;
  logic w_run_s;
  logic w_step_edge;
  logic w_bp_hit;
  logic w_cpu_en;

  // Bring the asynchronous button and switch into the clk domain and keep the
  // previous synchronized step level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_sync <= '0;
      r_run_sync  <= '0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step};
      r_run_sync  <= {r_run_sync[SYNC_STAGES-2:0], run_mode};
      r_step_prev <= w_step_s;
    end
  end

  assign w_step_s    = r_step_sync[SYNC_STAGES-1];
  assign w_run_s     = r_run_sync[SYNC_STAGES-1];
  // A held button produces exactly one edge per press.
  assign w_step_edge = w_step_s & ~r_step_prev;

`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
  assign w_bp_hit = bp_en & (pc == bp_addr);
`else
  // Breakpoint hardware absent; the ports stay for a stable pinout.
  logic w_unused_bp;
  assign w_unused_bp = ^{bp_en, bp_addr, pc};
  assign w_bp_hit    = 1'b0;
`endif

  // The breakpointed instruction itself must not execute, so the hit masks
  // the enable in the same cycle. STEP ignores the hit to allow stepping past.
  assign w_cpu_en = (r_state == STEP) | ((r_state == RUN) & ~w_bp_hit);

  // Run-control state machine; halted is set on entry to HALTED and sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= PAUSED;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        PAUSED: begin
          if (w_run_s)          r_state <= RUN;
          else if (w_step_edge) r_state <= STEP;
        end
        RUN: begin
          if (w_bp_hit) begin
            r_state <= BREAK;
          end else if (halt_req) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (!w_run_s) begin
            r_state <= PAUSED;
          end
        end
        STEP: begin
          if (halt_req) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (w_run_s) begin
            r_state <= RUN;
          end else begin
            r_state <= PAUSED;
          end
        end
        BREAK: begin
          if (w_step_edge) r_state <= STEP;
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= PAUSED;
        end
      endcase
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= '0;
    end else if (w_cpu_en && (r_instr_count != '1)) begin
      r_instr_count <= r_instr_count + CNT_WIDTH'(1);
    end
  end

  assign cpu_en      = w_cpu_en;
  assign halted      = r_halted;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire
